// File: rtl/sha256_pkg.sv
// Shared SHA-256 word type and the fixed rotate/shift amounts for the four sigma functions.
package sha256_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam int unsigned BS0_A = 2;
  localparam int unsigned BS0_B = 13;
  localparam int unsigned BS0_C = 22;

  localparam int unsigned BS1_A = 6;
  localparam int unsigned BS1_B = 11;
  localparam int unsigned BS1_C = 25;

  localparam int unsigned SS0_A = 7;
  localparam int unsigned SS0_B = 18;
  localparam int unsigned SS0_C = 3;

  localparam int unsigned SS1_A = 17;
  localparam int unsigned SS1_B = 19;
  localparam int unsigned SS1_C = 10;

  function automatic word_t rotr(input word_t v, input int unsigned n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

endpackage

// File: rtl/sha256_sigma_unit_if.sv
// Operand/result bundle of the sigma unit; small_sigma1 exists only with SHA256_SIGMA_SMALL1_EN.
import sha256_pkg::*;

interface sha256_sigma_unit_if;
  logic  en;
  word_t x;
  word_t big_sigma0;
  word_t big_sigma1;
  word_t small_sigma0;
`ifdef SHA256_SIGMA_SMALL1_EN
  word_t small_sigma1;
`endif
  logic  valid;

`ifdef SHA256_SIGMA_SMALL1_EN
  modport master (output en, x, input big_sigma0, big_sigma1, small_sigma0, small_sigma1, valid);
  modport slave  (input en, x, output big_sigma0, big_sigma1, small_sigma0, small_sigma1, valid);
`else
  modport master (output en, x, input big_sigma0, big_sigma1, small_sigma0, valid);
  modport slave  (input en, x, output big_sigma0, big_sigma1, small_sigma0, valid);
`endif
endinterface

// File: rtl/sha256_sigma_core.sv
// Combinational three-term XOR sigma: ROTR(a) ^ ROTR(b) ^ (ROTR or SHR)(c).
module sha256_sigma_core
  import sha256_pkg::*;
#(
  parameter int unsigned ROT_A   = 2,
  parameter int unsigned ROT_B   = 13,
  parameter int unsigned AMT_C   = 22,
  parameter bit          SHIFT_C = 1'b0
) (
  input  word_t x,
  output word_t y
);

  word_t term_c_s;

  // SHIFT_C is elaboration-time, so this mux folds away.
  assign term_c_s = SHIFT_C ? (x >> AMT_C) : rotr(x, AMT_C);
  assign y        = rotr(x, ROT_A) ^ rotr(x, ROT_B) ^ term_c_s;

endmodule

// File: rtl/sha256_sigma_unit.sv
// Registered SHA-256 sigma unit: one operand in, Σ0/Σ1/σ0 (and σ1 with SHA256_SIGMA_SMALL1_EN) out one cycle later.
module sha256_sigma_unit
  import sha256_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  sha256_sigma_unit_if.slave  bus
);

  word_t big_sigma0_s;
  word_t big_sigma1_s;
  word_t small_sigma0_s;
  word_t big_sigma0_r;
  word_t big_sigma1_r;
  word_t small_sigma0_r;
  logic  valid_r;

  sha256_sigma_core #(.ROT_A(BS0_A), .ROT_B(BS0_B), .AMT_C(BS0_C), .SHIFT_C(1'b0))
    u_big_sigma0 (.x(bus.x), .y(big_sigma0_s));

  sha256_sigma_core #(.ROT_A(BS1_A), .ROT_B(BS1_B), .AMT_C(BS1_C), .SHIFT_C(1'b0))
    u_big_sigma1 (.x(bus.x), .y(big_sigma1_s));

  sha256_sigma_core #(.ROT_A(SS0_A), .ROT_B(SS0_B), .AMT_C(SS0_C), .SHIFT_C(1'b1))
    u_small_sigma0 (.x(bus.x), .y(small_sigma0_s));

  // Result capture: results hold when en is low, valid marks only a fresh capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      big_sigma0_r   <= 32'h0000_0000;
      big_sigma1_r   <= 32'h0000_0000;
      small_sigma0_r <= 32'h0000_0000;
      valid_r        <= 1'b0;
    end else begin
      valid_r <= bus.en;
      if (bus.en) begin
        big_sigma0_r   <= big_sigma0_s;
        big_sigma1_r   <= big_sigma1_s;
        small_sigma0_r <= small_sigma0_s;
      end
    end
  end

  assign bus.big_sigma0   = big_sigma0_r;
  assign bus.big_sigma1   = big_sigma1_r;
  assign bus.small_sigma0 = small_sigma0_r;
  assign bus.valid        = valid_r;

`ifdef SHA256_SIGMA_SMALL1_EN
  word_t small_sigma1_s;
  word_t small_sigma1_r;

  sha256_sigma_core #(.ROT_A(SS1_A), .ROT_B(SS1_B), .AMT_C(SS1_C), .SHIFT_C(1'b1))
    u_small_sigma1 (.x(bus.x), .y(small_sigma1_s));

  // Optional σ1 register, same enable/reset behaviour as the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      small_sigma1_r <= 32'h0000_0000;
    end else if (bus.en) begin
      small_sigma1_r <= small_sigma1_s;
    end else begin
      small_sigma1_r <= small_sigma1_r;
    end
  end

  assign bus.small_sigma1 = small_sigma1_r;
`endif

endmodule

// File: tb/tb_sha256_sigma_unit.sv
// Self-checking bench for sha256_sigma_unit: scoreboard of model results plus directed vectors.
`timescale 1ns/1ps
module tb_sha256_sigma_unit;
  import sha256_pkg::*;

  typedef struct {
    word_t b0;
    word_t b1;
    word_t s0;
    word_t s1;
  } exp_t;

  typedef struct {
    word_t x;
    word_t b0;
    word_t b1;
    word_t s0;
    word_t s1;
  } vec_t;

  logic  clk;
  logic  rst;
  exp_t  sb[$];
  int    pass_count;
  int    check_count;

  sha256_sigma_unit_if bus();

  sha256_sigma_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t m_rotr(input word_t v, input int n);
    logic [63:0] t;
    t = {v, v} >> n;
    return t[31:0];
  endfunction

  function automatic exp_t model(input word_t v);
    exp_t e;
    e.b0 = m_rotr(v, 2)  ^ m_rotr(v, 13) ^ m_rotr(v, 22);
    e.b1 = m_rotr(v, 6)  ^ m_rotr(v, 11) ^ m_rotr(v, 25);
    e.s0 = m_rotr(v, 7)  ^ m_rotr(v, 18) ^ (v >> 3);
    e.s1 = m_rotr(v, 17) ^ m_rotr(v, 19) ^ (v >> 10);
    return e;
  endfunction

  // drive one cycle's inputs, record expectation, and land 1ns after the edge
  task automatic drive(input logic e, input word_t v);
    bus.en = e;
    bus.x  = v;
    if (e) sb.push_back(model(v));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t junk;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.x  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_count++;
    if ({bus.big_sigma0, bus.big_sigma1, bus.small_sigma0, bus.valid} !== {96'h0, 1'b0})
      $display("FAIL reset_init got %h %h %h v=%b want 0 0 0 v=0",
               bus.big_sigma0, bus.big_sigma1, bus.small_sigma0, bus.valid);
    else pass_count++;
    rst = 1'b0;
    drive(1'b1, 32'h0000_0001);
    junk = sb.pop_front();
    check_count++;
    if (bus.big_sigma0 !== 32'h4008_0400 || bus.valid !== 1'b1)
      $display("FAIL reset_pre got %h v=%b want 40080400 v=1", bus.big_sigma0, bus.valid);
    else pass_count++;
    // asynchronous assertion between edges, with a capture pending
    bus.en = 1'b1;
    bus.x  = 32'h0000_3FFF;
    #2;
    rst = 1'b1;
    #1;
    check_count++;
    if ({bus.big_sigma0, bus.big_sigma1, bus.small_sigma0, bus.valid} !== {96'h0, 1'b0})
      $display("FAIL reset_async got %h %h %h v=%b want 0 0 0 v=0",
               bus.big_sigma0, bus.big_sigma1, bus.small_sigma0, bus.valid);
    else pass_count++;
`ifdef SHA256_SIGMA_SMALL1_EN
    check_count++;
    if (bus.small_sigma1 !== 32'h0)
      $display("FAIL reset_s1 got %h want 00000000", bus.small_sigma1);
    else pass_count++;
`endif
    @(posedge clk);
    #1;
    check_count++;
    if ({bus.big_sigma0, bus.valid} !== {32'h0, 1'b0})
      $display("FAIL reset_wins_en got %h v=%b want 0 v=0", bus.big_sigma0, bus.valid);
    else pass_count++;
    #3;
    rst = 1'b0;
    bus.en = 1'b0;
    sb.delete();
    drive(1'b0, 32'hFFFF_FFFF);
    check_count++;
    if ({bus.big_sigma0, bus.valid} !== {32'h0, 1'b0})
      $display("FAIL reset_no_stale got %h v=%b want 0 v=0", bus.big_sigma0, bus.valid);
    else pass_count++;
  endtask

  task automatic test_vectors;
    vec_t tbl[4];
    exp_t e;
    tbl[0] = '{32'h0000_3FFF, 32'h3F07_F3FE, 32'h03FF_FF78, 32'hF1FF_C780, 32'h1800_600F};
    tbl[1] = '{32'h0000_0001, 32'h4008_0400, 32'h0420_0080, 32'h0200_4000, 32'h0000_A000};
    tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1FFF_FFFF, 32'h003F_FFFF};
    tbl[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, tbl[i].x);
      bus.en = 1'b0;
      check_count++;
      if (sb.size() == 0) begin
        $display("FAIL vec_sb_empty x=%h", tbl[i].x);
        continue;
      end
      e = sb.pop_front();
      if (bus.valid !== 1'b1 || bus.big_sigma0 !== e.b0 || bus.big_sigma1 !== e.b1 ||
          bus.small_sigma0 !== e.s0)
        $display("FAIL vec_model x=%h got %h %h %h v=%b want %h %h %h v=1", tbl[i].x,
                 bus.big_sigma0, bus.big_sigma1, bus.small_sigma0, bus.valid, e.b0, e.b1, e.s0);
      else pass_count++;
      check_count++;
      if (bus.big_sigma0 !== tbl[i].b0 || bus.big_sigma1 !== tbl[i].b1 ||
          bus.small_sigma0 !== tbl[i].s0)
        $display("FAIL vec_const x=%h got %h %h %h want %h %h %h", tbl[i].x,
                 bus.big_sigma0, bus.big_sigma1, bus.small_sigma0, tbl[i].b0, tbl[i].b1, tbl[i].s0);
      else pass_count++;
`ifdef SHA256_SIGMA_SMALL1_EN
      check_count++;
      if (bus.small_sigma1 !== tbl[i].s1 || bus.small_sigma1 !== e.s1)
        $display("FAIL vec_s1 x=%h got %h want %h", tbl[i].x, bus.small_sigma1, tbl[i].s1);
      else pass_count++;
`endif
    end
  endtask

  task automatic test_hold;
    exp_t junk;
    drive(1'b1, 32'h0000_3FFF);
    junk = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'hFFFF_FFFF);
      check_count++;
      if (bus.big_sigma0 !== 32'h3F07_F3FE || bus.big_sigma1 !== 32'h03FF_FF78 ||
          bus.small_sigma0 !== 32'hF1FF_C780 || bus.valid !== 1'b0)
        $display("FAIL hold cyc=%0d got %h %h %h v=%b want 3f07f3fe 03ffff78 f1ffc780 v=0", i,
                 bus.big_sigma0, bus.big_sigma1, bus.small_sigma0, bus.valid);
      else pass_count++;
`ifdef SHA256_SIGMA_SMALL1_EN
      check_count++;
      if (bus.small_sigma1 !== 32'h1800_600F)
        $display("FAIL hold_s1 cyc=%0d got %h want 1800600f", i, bus.small_sigma1);
      else pass_count++;
`endif
    end
  endtask

  task automatic test_back_to_back;
    word_t stim[$];
    exp_t  e;
    stim = '{32'h0000_0000, 32'h0000_0001, 32'h0000_3FFF};
    for (int i = 0; i < 20; i++) stim.push_back(word_t'($urandom));
    foreach (stim[i]) begin
      drive(1'b1, stim[i]);
      check_count++;
      if (sb.size() == 0) begin
        $display("FAIL stream_sb_empty idx=%0d", i);
        continue;
      end
      e = sb.pop_front();
      if (bus.valid !== 1'b1 || bus.big_sigma0 !== e.b0 || bus.big_sigma1 !== e.b1 ||
          bus.small_sigma0 !== e.s0)
        $display("FAIL stream idx=%0d x=%h got %h %h %h v=%b want %h %h %h v=1", i, stim[i],
                 bus.big_sigma0, bus.big_sigma1, bus.small_sigma0, bus.valid, e.b0, e.b1, e.s0);
      else pass_count++;
`ifdef SHA256_SIGMA_SMALL1_EN
      check_count++;
      if (bus.small_sigma1 !== e.s1)
        $display("FAIL stream_s1 idx=%0d got %h want %h", i, bus.small_sigma1, e.s1);
      else pass_count++;
`endif
    end
    drive(1'b0, 32'h0000_0000);
    check_count++;
    if (bus.valid !== 1'b0 || sb.size() != 0)
      $display("FAIL stream_end v=%b pending=%0d want v=0 pending=0", bus.valid, sb.size());
    else pass_count++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    pass_count  = 0;
    check_count = 0;
    rst    = 1'b1;
    bus.en = 1'b0;
    bus.x  = 32'h0;
    test_reset();
    test_vectors();
    test_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
